// File: rtl/m_dram_app_resp.sv
// Behavioural DRAM application-interface responder: calibration delay, 4-deep write-data
// FIFO, byte-masked single-beat writes and fixed-latency reads from a block-RAM store.
module m_dram_app_resp #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_CMD_WIDTH  = 3,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int MEM_LINES      = 512,
  parameter int RD_LATENCY     = 8,
  parameter int CALIB_CYCLES   = 16,
  parameter int RDY_PERIOD     = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_x,
  input  logic [APP_ADDR_WIDTH-1:0] i_app_addr,
  input  logic [APP_CMD_WIDTH-1:0]  i_app_cmd,
  input  logic                      i_app_en,
  output logic                      o_app_rdy,
  input  logic [APP_DATA_WIDTH-1:0] i_app_wdf_data,
  input  logic [APP_MASK_WIDTH-1:0] i_app_wdf_mask,
  input  logic                      i_app_wdf_wren,
  input  logic                      i_app_wdf_end,
  output logic                      o_app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0] o_app_rd_data,
  output logic                      o_app_rd_data_valid,
  output logic                      o_app_rd_data_end,
  output logic                      o_init_calib_complete
);

  localparam int LW = $clog2(MEM_LINES);
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int GP = (RDY_PERIOD == 0) ? 1 : RDY_PERIOD;
  localparam int GW = $clog2(GP + 1);
  localparam int DW = APP_DATA_WIDTH;
  localparam int MW = APP_MASK_WIDTH;
  localparam int FW = DW + MW;

  typedef enum logic [1:0] {CALIB, READY, WAIT_WDATA} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] calib_cnt_q, calib_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [LW-1:0] wait_line_q, wait_line_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0][FW-1:0] fifo_q;

  logic [RD_LATENCY:0]           vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0][DW-1:0] dly_q;
  logic [DW-1:0]                 rd_data_q, rd_data_d;
  logic [DW-1:0]                 mem [MEM_LINES];

  logic          gap_cycle, cmd_acc, wdf_acc, cmd_wr, rd_acc;
  logic          fifo_empty, fifo_full, data_avail, wr_exec, push, pop;
  logic [LW-1:0] cmd_line, wr_line;
  logic [FW-1:0] head;
  logic [DW-1:0] head_data;
  logic [MW-1:0] head_mask;
  logic          unused_ok;

  // Burst-end strobe and the address bits outside the line index carry no meaning here.
  assign unused_ok = ^{i_app_wdf_end, i_app_addr};

  assign cmd_line   = i_app_addr[3 +: LW];
  assign gap_cycle  = (RDY_PERIOD != 0) && (gap_cnt_q == GW'(GP - 1));
  assign cmd_acc    = i_app_en && o_app_rdy;
  assign wdf_acc    = i_app_wdf_wren && o_app_wdf_rdy;
  assign cmd_wr     = (i_app_cmd == APP_CMD_WIDTH'(0));
  assign rd_acc     = cmd_acc && (i_app_cmd == APP_CMD_WIDTH'(1));
  assign fifo_empty = (cnt_q == 3'd0);
  assign fifo_full  = (cnt_q == 3'd4);
  // An empty FIFO lets a same-cycle beat bypass straight into the write.
  assign head       = fifo_empty ? {i_app_wdf_mask, i_app_wdf_data} : fifo_q[rd_ptr_q];
  assign head_data  = head[DW-1:0];
  assign head_mask  = head[FW-1 -: MW];
  assign data_avail = !fifo_empty || wdf_acc;
  assign wr_exec    = data_avail && ((cmd_acc && cmd_wr) || (state_q == WAIT_WDATA));
  assign wr_line    = (state_q == WAIT_WDATA) ? wait_line_q : cmd_line;
  assign pop        = wr_exec && !fifo_empty;
  assign push       = wdf_acc && !(wr_exec && fifo_empty);

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) state_q <= CALIB;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      CALIB:      if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) state_d = READY;
      READY:      if (cmd_acc && cmd_wr && !data_avail) state_d = WAIT_WDATA;
      WAIT_WDATA: if (data_avail) state_d = READY;
      default:    state_d = CALIB;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_app_rdy             = 1'b0;
    o_app_wdf_rdy         = 1'b0;
    o_init_calib_complete = 1'b0;
    case (state_q)
      READY: begin
        o_app_rdy             = !gap_cycle;
        o_app_wdf_rdy         = !fifo_full;
        o_init_calib_complete = 1'b1;
      end
      WAIT_WDATA: begin
        o_app_wdf_rdy         = !fifo_full;
        o_init_calib_complete = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    calib_cnt_d = calib_cnt_q;
    if (state_q == CALIB) calib_cnt_d = calib_cnt_q + 1'b1;
    gap_cnt_d = '0;
    if (state_q != CALIB && gap_cnt_q != GW'(GP - 1)) gap_cnt_d = gap_cnt_q + 1'b1;
    wait_line_d = (cmd_acc && cmd_wr && !data_avail) ? cmd_line : wait_line_q;
    wr_ptr_d    = wr_ptr_q + {1'b0, push};
    rd_ptr_d    = rd_ptr_q + {1'b0, pop};
    cnt_d       = cnt_q + {2'b0, push} - {2'b0, pop};
    vld_pipe_d  = {vld_pipe_q[RD_LATENCY-1:0], rd_acc};
    rd_data_d   = vld_pipe_q[RD_LATENCY-1] ? dly_q[RD_LATENCY-1] : rd_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      calib_cnt_q <= '0;
      gap_cnt_q   <= '0;
      wait_line_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      vld_pipe_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      calib_cnt_q <= calib_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wait_line_q <= wait_line_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= {i_app_wdf_mask, i_app_wdf_data};
  end

  // Storage survives reset; only one command is accepted per edge, so a write and a
  // read never target the array on the same edge.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < MW; b++)
      if (wr_exec && !head_mask[b]) mem[wr_line][8*b +: 8] <= head_data[8*b +: 8];
    if (rd_acc) dly_q[0] <= mem[cmd_line];
    for (int k = 1; k < RD_LATENCY; k++) dly_q[k] <= dly_q[k-1];
  end

  assign o_app_rd_data       = rd_data_q;
  assign o_app_rd_data_valid = vld_pipe_q[RD_LATENCY];
  assign o_app_rd_data_end   = vld_pipe_q[RD_LATENCY];

endmodule
